// File: rtl/fetch_inst_buffer_pkg.sv
// Shared types for the fetch-to-decode instruction buffer: the payload that
// travels from fetch to decode, the wrap-bit pointer and pointer helpers.
package fetch_inst_buffer_pkg;

  localparam int IB_DEPTH        = 16;
  localparam int IB_INPUT_WIDTH  = 4;
  localparam int IB_OUTPUT_WIDTH = 4;
  localparam int IB_IDX_W        = $clog2(IB_DEPTH);

  // One fetched instruction as handed to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0]  ftq_idx;
    logic [1:0]  ftq_offset;
    logic        has_except;
  } fetch_entry_t;

  // Circular-buffer pointer: the extra wrap bit separates full from empty.
  typedef struct packed {
    logic                wrap;
    logic [IB_IDX_W-1:0] idx;
  } inst_buf_ptr_t;

  // Advance a pointer by n slots; the wrap bit toggles when idx rolls over.
  function automatic inst_buf_ptr_t ptr_add(input inst_buf_ptr_t p,
                                            input logic [IB_IDX_W:0] n);
    logic [IB_IDX_W:0] sum;
    sum = {p.wrap, p.idx} + n;
    return inst_buf_ptr_t'(sum);
  endfunction

  // Occupancy between two pointers (tail - head), range 0..IB_DEPTH.
  function automatic logic [IB_IDX_W:0] ptr_diff(input inst_buf_ptr_t tail,
                                                 input inst_buf_ptr_t head);
    return {tail.wrap, tail.idx} - {head.wrap, head.idx};
  endfunction

endpackage

// File: rtl/fetch_inst_buffer_count_ones.sv
// Parameterised population count, used for enqueue and dequeue lane counts.
module fetch_inst_buffer_count_ones #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_bits,
  output logic [CW-1:0] o_cnt
);

  // Sum the set bits of the input vector.
  always_comb begin
    o_cnt = {CW{1'b0}};
    for (int i = 0; i < W; i++) begin
      o_cnt = o_cnt + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/fetch_inst_buffer.sv
// Instruction buffer between fetch and decode. Fetch writes up to
// INPUT_WIDTH entries per cycle; decode sees up to OUTPUT_WIDTH oldest
// entries in program order, with a group always ending at an excepting
// instruction. A squash empties the buffer on the next edge.
// The pointer type is sized from IB_DEPTH, so DEPTH must stay equal to it.
module fetch_inst_buffer
  import fetch_inst_buffer_pkg::*;
#(
  parameter int DEPTH        = IB_DEPTH,
  parameter int INPUT_WIDTH  = IB_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = IB_OUTPUT_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_squash_vld,
  input  logic [INPUT_WIDTH-1:0]               i_enq_vld,
  input  fetch_entry_t [INPUT_WIDTH-1:0]       i_enq_entry,
  output logic                                 o_can_enq,
  output logic [OUTPUT_WIDTH-1:0]              o_deq_vld,
  output fetch_entry_t [OUTPUT_WIDTH-1:0]      o_deq_entry,
  input  logic                                 i_deq_ready
);

  localparam int PTR_W   = IB_IDX_W + 1;
  localparam int ENQ_CW  = $clog2(INPUT_WIDTH + 1);
  localparam int DEQ_CW  = $clog2(OUTPUT_WIDTH + 1);
  localparam int LANE_W  = $clog2(INPUT_WIDTH);

  inst_buf_ptr_t             head_q;
  inst_buf_ptr_t             head_d;
  inst_buf_ptr_t             tail_q;
  inst_buf_ptr_t             tail_d;
  fetch_entry_t              mem_q [DEPTH];
  fetch_entry_t              mem_d [DEPTH];

  logic [PTR_W-1:0]          count_s;
  logic [PTR_W-1:0]          free_s;
  logic                      enq_fire_s;
  logic [INPUT_WIDTH-1:0]    enq_mask_s;
  logic [OUTPUT_WIDTH-1:0]   deq_mask_s;
  logic [ENQ_CW-1:0]         enq_num_s;
  logic [DEQ_CW-1:0]         deq_num_s;

  // Occupancy and enqueue permission, both from the registered pointers so a
  // same-cycle dequeue never opens room for fetch early.
  always_comb begin
    count_s   = ptr_diff(tail_q, head_q);
    free_s    = PTR_W'(DEPTH) - count_s;
    o_can_enq = (free_s >= PTR_W'(INPUT_WIDTH));
  end

  // Present the oldest entries; stop the group after an excepting entry.
  always_comb begin : p_deq_lanes
    logic cut;
    cut = 1'b0;
    for (int k = 0; k < OUTPUT_WIDTH; k++) begin
      o_deq_entry[k] = mem_q[head_q.idx + IB_IDX_W'(k)];
      o_deq_vld[k]   = (PTR_W'(k) < count_s) && !cut;
      if (o_deq_vld[k] && o_deq_entry[k].has_except) begin
        cut = 1'b1;
      end else begin
        cut = cut;
      end
    end
  end

  // Qualify the lane masks that actually move the pointers this cycle.
  always_comb begin
    enq_fire_s = o_can_enq && (|i_enq_vld) && !i_squash_vld;
    if (enq_fire_s) begin
      enq_mask_s = i_enq_vld;
    end else begin
      enq_mask_s = {INPUT_WIDTH{1'b0}};
    end
    if (i_deq_ready) begin
      deq_mask_s = o_deq_vld;
    end else begin
      deq_mask_s = {OUTPUT_WIDTH{1'b0}};
    end
  end

  fetch_inst_buffer_count_ones #(
    .W  (INPUT_WIDTH),
    .CW (ENQ_CW)
  ) u_enq_cnt (
    .i_bits (enq_mask_s),
    .o_cnt  (enq_num_s)
  );

  fetch_inst_buffer_count_ones #(
    .W  (OUTPUT_WIDTH),
    .CW (DEQ_CW)
  ) u_deq_cnt (
    .i_bits (deq_mask_s),
    .o_cnt  (deq_num_s)
  );

  // Next head/tail: squash wins over any same-cycle enqueue or dequeue.
  always_comb begin
    if (i_squash_vld) begin
      head_d = inst_buf_ptr_t'({PTR_W{1'b0}});
      tail_d = inst_buf_ptr_t'({PTR_W{1'b0}});
    end else begin
      head_d = ptr_add(head_q, PTR_W'(deq_num_s));
      tail_d = ptr_add(tail_q, PTR_W'(enq_num_s));
    end
  end

  // Next storage contents: each slot takes the lane that lands on it.
  always_comb begin : p_mem_next
    logic [IB_IDX_W-1:0] off;
    for (int s = 0; s < DEPTH; s++) begin
      off = IB_IDX_W'(s) - tail_q.idx;
      if ((off < IB_IDX_W'(INPUT_WIDTH)) && enq_mask_s[off[LANE_W-1:0]]) begin
        mem_d[s] = i_enq_entry[off[LANE_W-1:0]];
      end else begin
        mem_d[s] = mem_q[s];
      end
    end
  end

  // Pointer registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= inst_buf_ptr_t'({PTR_W{1'b0}});
      tail_q <= inst_buf_ptr_t'({PTR_W{1'b0}});
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Self-checking bench for fetch_inst_buffer: a queue model of the buffer is
// compared with the DUT every cycle, plus directed scenario pins.
module tb_fetch_inst_buffer;
  import fetch_inst_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int OW    = 4;

  logic                     clk;
  logic                     rst;
  logic                     squash;
  logic [IW-1:0]            enq_vld;
  fetch_entry_t [IW-1:0]    enq_entry;
  logic                     can_enq;
  logic [OW-1:0]            deq_vld;
  fetch_entry_t [OW-1:0]    deq_entry;
  logic                     deq_ready;

  int          n_cmp;
  int          n_bad;
  int          illegal_cnt;
  int unsigned seq;
  fetch_entry_t m_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_inst_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .i_squash_vld (squash),
    .i_enq_vld    (enq_vld),
    .i_enq_entry  (enq_entry),
    .o_can_enq    (can_enq),
    .o_deq_vld    (deq_vld),
    .o_deq_entry  (deq_entry),
    .i_deq_ready  (deq_ready)
  );

  // Expected valid lanes: oldest min(4, size) entries, ending after an exception.
  function automatic logic [OW-1:0] model_vld();
    logic [OW-1:0] v;
    bit stop;
    v = '0;
    stop = 0;
    for (int k = 0; k < OW; k++) begin
      if (k < m_q.size() && !stop) begin
        v[k] = 1'b1;
        if (m_q[k].has_except) stop = 1;
      end
    end
    return v;
  endfunction

  function automatic bit model_can();
    return (DEPTH - m_q.size()) >= IW;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic fetch_entry_t mk_entry(input logic exc);
    fetch_entry_t e;
    seq++;
    e.pc         = seq * 4;
    e.inst       = $urandom;
    e.ftq_idx    = seq[5:2];
    e.ftq_offset = seq[1:0];
    e.has_except = exc;
    return e;
  endfunction

  // Model update on the same edge the DUT samples its inputs.
  always @(posedge clk or negedge rst) begin : mdl
    logic [OW-1:0] v;
    bit can;
    if (!rst) begin
      m_q.delete();
    end else begin
      v   = model_vld();
      can = model_can();
      if (|enq_vld && !can) illegal_cnt++;
      if (squash) begin
        m_q.delete();
      end else begin
        if (deq_ready) begin
          for (int k = 0; k < OW; k++) if (v[k]) void'(m_q.pop_front());
        end
        if (can) begin
          for (int k = 0; k < IW; k++) if (enq_vld[k]) m_q.push_back(enq_entry[k]);
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin : cmp
    logic [OW-1:0] ev;
    ev = model_vld();
    chk("deq_vld", deq_vld, ev);
    chk("can_enq", can_enq, model_can());
    chk("count", dut.count_s, m_q.size());
    for (int k = 0; k < OW; k++) begin
      if (ev[k]) chk("deq_entry", deq_entry[k], m_q[k]);
    end
  end

  task automatic cycle(input int n, input bit rdy, input bit sq,
                       input logic [IW-1:0] exc, input bit respect);
    int nn;
    @(negedge clk);
    #1;
    nn = n;
    if (respect && !model_can()) nn = 0;
    for (int k = 0; k < IW; k++) begin
      enq_vld[k]   = (k < nn);
      enq_entry[k] = (k < nn) ? mk_entry(exc[k]) : '0;
    end
    deq_ready = rdy;
    squash    = sq;
    @(posedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (m_q.size() != 0 && guard < 40) begin
      cycle(0, 1'b1, 1'b0, 4'b0000, 1'b1);
      guard++;
    end
    chk("drain_empty", m_q.size(), 0);
  endtask

  initial begin
    int unsigned s0;
    n_cmp = 0; n_bad = 0; illegal_cnt = 0; seq = 0;
    rst = 1'b0; squash = 1'b0; enq_vld = '0; enq_entry = '0; deq_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // 1. reset mid-traffic at count 7
    cycle(4, 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle(3, 1'b0, 1'b0, 4'b0000, 1'b1);
    #1;
    chk("pre_rst_count", m_q.size(), 7);
    #2;
    enq_vld = '0;
    rst = 1'b0;
    #1;
    chk("rst_deq_vld", deq_vld, 4'b0000);
    chk("rst_can_enq", can_enq, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    cycle(0, 1'b0, 1'b0, 4'b0000, 1'b1);

    // 2. fill to DEPTH, then an ignored illegal enqueue
    repeat (4) cycle(4, 1'b0, 1'b0, 4'b0000, 1'b1);
    #1;
    chk("fill_can_enq", can_enq, 1'b0);
    chk("fill_count", m_q.size(), 16);
    cycle(4, 1'b0, 1'b0, 4'b0000, 1'b0);
    #1;
    chk("fill_ignored", dut.count_s, 5'd16);
    chk("illegal_seen", illegal_cnt, 1);
    drain();

    // 3. continuous 4-in / 4-out
    for (int i = 0; i < 100; i++) begin
      cycle(4, 1'b1, 1'b0, 4'b0000, 1'b1);
      #1;
      chk("tput_no_bubble", deq_vld, 4'b1111);
    end
    drain();

    // 4. move head to slot 13, then partial groups across the boundary
    repeat (3) cycle(4, 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle(1, 1'b0, 1'b0, 4'b0000, 1'b1);
    drain();
    cycle(3, 1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(3, 1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(2, 1'b1, 1'b0, 4'b0000, 1'b1);
    drain();

    // 5. exception on lane 1 ends the group
    s0 = seq;
    cycle(4, 1'b0, 1'b0, 4'b0010, 1'b1);
    #1;
    chk("exc_vld", deq_vld, 4'b0011);
    cycle(0, 1'b1, 1'b0, 4'b0000, 1'b1);
    #1;
    chk("exc_next_pc", deq_entry[0].pc, (s0 + 3) * 4);
    chk("exc_next_vld", deq_vld, 4'b0011);
    drain();

    // 6. squash with enqueue and dequeue at count 9
    cycle(4, 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle(4, 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle(1, 1'b0, 1'b0, 4'b0000, 1'b1);
    #1;
    chk("sq_pre_count", m_q.size(), 9);
    cycle(4, 1'b1, 1'b1, 4'b0000, 1'b1);
    #1;
    chk("sq_deq_vld", deq_vld, 4'b0000);
    chk("sq_count", dut.count_s, 5'd0);
    s0 = seq;
    cycle(4, 1'b0, 1'b0, 4'b0000, 1'b1);
    #1;
    chk("sq_fresh_pc", deq_entry[0].pc, (s0 + 1) * 4);
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [IW-1:0] exc;
      for (int k = 0; k < IW; k++) exc[k] = ($urandom_range(0, 7) == 0);
      cycle($urandom_range(0, 4), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 31) == 0), exc, 1'b1);
    end
    drain();
    cycle(0, 1'b0, 1'b0, 4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
